seven_seg_monitor: RTL

SEVEN_SEG_MONITOR -- requirements
Module: seven_seg_monitor

---
 rtl/seven_seg_pkg.sv | 32 +++
 rtl/seven_seg_monitor_decode.sv | 29 ++
 rtl/seven_seg_monitor.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan monitor: segment patterns (active low, g..a),
// anode select codes, decode result codes and the monitor FSM encoding.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_D0   = 4'b1110;
    localparam logic [3:0] AN_D1   = 4'b1101;
    localparam logic [3:0] AN_D2   = 4'b1011;
    localparam logic [3:0] AN_D3   = 4'b0111;
    localparam logic [3:0] AN_NONE = 4'b1111;

    localparam logic [3:0] DIG_BAD   = 4'hE;
    localparam logic [3:0] DIG_BLANK = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_STALE   = 2'd2
    } mon_state_e;

endpackage

// File: rtl/seven_seg_monitor_decode.sv
// Combinational segment-pattern to digit decoder; unknown patterns flag bad and return DIG_BAD.
module seg7_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] pat,
    output logic [3:0] digit,
    output logic       bad
);

    always_comb begin
        digit = DIG_BAD;
        bad   = 1'b0;
        case (pat)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
            SEG_BLANK: digit = DIG_BLANK;
            default:   bad   = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_seg_monitor.sv
// Reconstructs the 4-digit value shown on a multiplexed seven-segment display by
// observing its segment and anode lines, with scan-error and stale-scan detection.
module seven_seg_monitor
    import seven_seg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] cntr,
    output logic [3:0]  dp_pos,
    output logic        valid,
    output logic        err_seg,
    output logic        err_an,
    output logic        timeout
);

    localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [7:0]       seg_p0;
    logic [3:0]       an_p0;
    logic [3:0]       digit;
    logic             bad;
    logic             active;
    logic             multi;
    logic [1:0]       idx;
    logic [3:0]       sel;
    mon_state_e       state_q;
    mon_state_e       state_d;
    logic [3:0]       mask_p1;
    logic [3:0]       mask_set;
    logic             complete;
    logic             stale_hit;
    logic [CNT_W-1:0] idle_cnt;
    logic [3:0]       dig_sh [4];
    logic [3:0]       dp_sh;
    logic [15:0]      frame_val;
    logic [3:0]       frame_dp;
    logic [15:0]      cntr_p1;
    logic [3:0]       dp_p1;
    logic             vld_p1;
    logic             err_seg_p1;
    logic             err_an_p1;

    // Stage p0: input capture
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_p0 <= 8'hFF;
            an_p0  <= AN_NONE;
        end else begin
            seg_p0 <= seg;
            an_p0  <= an;
        end
    end

    seg7_pattern_decode u_decode (
        .pat   (seg_p0[6:0]),
        .digit (digit),
        .bad   (bad)
    );

    always_comb begin
        active = 1'b0;
        multi  = 1'b0;
        idx    = 2'd0;
        case (an_p0)
            AN_D0:   begin active = 1'b1; idx = 2'd0; end
            AN_D1:   begin active = 1'b1; idx = 2'd1; end
            AN_D2:   begin active = 1'b1; idx = 2'd2; end
            AN_D3:   begin active = 1'b1; idx = 2'd3; end
            AN_NONE: ;
            default: multi = 1'b1;
        endcase
        sel = active ? ~an_p0 : 4'b0000;
    end

    // Completing digit bypasses its shadow so it lands in the same published frame.
    always_comb begin
        mask_set  = ((state_q == ST_STALE) ? 4'b0000 : mask_p1) | sel;
        complete  = active && (mask_set == 4'hF);
        stale_hit = !active && (idle_cnt == CNT_LIMIT);
        frame_val = '0;
        frame_dp  = '0;
        for (int i = 0; i < 4; i++) begin
            frame_val[4*i +: 4] = sel[i] ? digit : dig_sh[i];
            frame_dp[i]         = sel[i] ? ~seg_p0[7] : dp_sh[i];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (active)         state_d = ST_COLLECT;
                else if (stale_hit) state_d = ST_STALE;
            end
            ST_COLLECT: begin
                if (complete)       state_d = ST_IDLE;
                else if (stale_hit) state_d = ST_STALE;
            end
            ST_STALE: begin
                if (active)         state_d = ST_COLLECT;
            end
            default:                state_d = ST_IDLE;
        endcase
    end

    // Stage p1: capture, frame publish and status
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mask_p1    <= '0;
            idle_cnt   <= '0;
            dp_sh      <= '0;
            cntr_p1    <= '0;
            dp_p1      <= '0;
            vld_p1     <= 1'b0;
            err_seg_p1 <= 1'b0;
            err_an_p1  <= 1'b0;
            for (int i = 0; i < 4; i++) dig_sh[i] <= '0;
        end else begin
            state_q    <= state_d;
            vld_p1     <= complete;
            err_seg_p1 <= active && bad;
            err_an_p1  <= multi;

            if (active)                      idle_cnt <= '0;
            else if (idle_cnt != CNT_LIMIT)  idle_cnt <= idle_cnt + CNT_W'(1);

            if (complete || state_d == ST_STALE) mask_p1 <= '0;
            else                                 mask_p1 <= mask_set;

            if (active) begin
                dig_sh[idx] <= digit;
                dp_sh[idx]  <= ~seg_p0[7];
            end
            if (complete) begin
                cntr_p1 <= frame_val;
                dp_p1   <= frame_dp;
            end
        end
    end

    assign cntr    = cntr_p1;
    assign dp_pos  = dp_p1;
    assign valid   = vld_p1;
    assign err_seg = err_seg_p1;
    assign err_an  = err_an_p1;
    assign timeout = (state_q == ST_STALE);

endmodule
